// File: rtl/regbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbus_arbiter
// Purpose  : Two-master arbiter onto a single 8-bit slave register bus.
//            Master 0 is the SPI bridge, master 1 the UART command engine.
//            One transaction at a time: IDLE -> ACCESS -> DONE -> IDLE.
//            Ties are round-robin. A master can hold the grant for its next
//            transaction through mX_lock. A busy slave is abandoned after
//            TIMEOUT wait cycles.
// Ports    : clk, rst_n (async, active-low)
//            mX_req/wr/addr/wdata/lock : master request side (X = 0, 1)
//            mX_ack/err/rdata          : master completion side
//            s_en/wr/addr/wdata        : slave bus command
//            s_rdata, s_busy           : slave bus response
// Revision : 1.0 - initial release
// ============================================================================
module regbus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m0_wr,
  input  logic       m1_wr,
  input  logic [2:0] m0_addr,
  input  logic [2:0] m1_addr,
  input  logic [7:0] m0_wdata,
  input  logic [7:0] m1_wdata,
  input  logic       m0_lock,
  input  logic       m1_lock,
  output logic       m0_ack,
  output logic       m1_ack,
  output logic       m0_err,
  output logic       m1_err,
  output logic [7:0] m0_rdata,
  output logic [7:0] m1_rdata,
  output logic       s_en,
  output logic       s_wr,
  output logic [2:0] s_addr,
  output logic [7:0] s_wdata,
  input  logic [7:0] s_rdata,
  input  logic       s_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       r_owner;       // 0 = master 0, 1 = master 1
  logic       r_wr;
  logic [2:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_err;
  logic [7:0] r_m0_rdata;
  logic [7:0] r_m1_rdata;
  logic       r_last_grant;
  logic       r_lock_valid;
  logic [7:0] r_wait;

  logic       w_any_req;
  logic       w_grant;
  logic       w_s_en;
  logic       w_timeout;
  logic [7:0] w_cap;

  assign w_any_req = m0_req | m1_req;
  assign w_s_en    = (r_state == ACCESS) && !s_busy;
  assign w_timeout = (r_state == ACCESS) && s_busy && (r_wait == TIMEOUT);
  // Writes return zero so a stale slave value never leaks to the master.
  assign w_cap     = r_wr ? 8'h00 : s_rdata;

  // The locked master is always the last owner, since lock_valid is only
  // ever loaded from the owner's lock input.
  always_comb begin
    w_grant = m1_req;
    if (r_lock_valid && (r_last_grant ? m1_req : m0_req)) begin
      w_grant = r_last_grant;
    end else if (m0_req && m1_req) begin
      w_grant = ~r_last_grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ACCESS;
      ACCESS:  if (w_s_en || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= 3'd0;
      r_wdata      <= 8'h00;
      r_err        <= 1'b0;
      r_m0_rdata   <= 8'h00;
      r_m1_rdata   <= 8'h00;
      r_last_grant <= 1'b1;
      r_lock_valid <= 1'b0;
      r_wait       <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_wr    <= w_grant ? m1_wr    : m0_wr;
            r_addr  <= w_grant ? m1_addr  : m0_addr;
            r_wdata <= w_grant ? m1_wdata : m0_wdata;
            r_err   <= 1'b0;
          end
        end
        ACCESS: begin
          if (w_s_en || w_timeout) begin
            r_err <= w_timeout;
            if (r_owner) begin
              r_m1_rdata <= w_timeout ? 8'h00 : w_cap;
            end else begin
              r_m0_rdata <= w_timeout ? 8'h00 : w_cap;
            end
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        DONE: begin
          r_last_grant <= r_owner;
          r_lock_valid <= r_owner ? m1_lock : m0_lock;
          r_wait       <= 8'd0;
        end
        default: begin
        end
      endcase
    end
  end

  assign s_en     = w_s_en;
  assign s_wr     = r_wr;
  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;

  assign m0_ack   = (r_state == DONE) && !r_owner;
  assign m1_ack   = (r_state == DONE) &&  r_owner;
  assign m0_err   = m0_ack & r_err;
  assign m1_err   = m1_ack & r_err;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_regbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbus_arbiter
// Purpose  : Self-checking bench for regbus_arbiter. Expected slave accesses
//            and master completions are queued when a request is driven and
//            consumed when the DUT issues s_en / ack. A small slave memory
//            model answers reads; a shadow copy supplies expected read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbus_arbiter;

  localparam logic [7:0] TMO = 8'd10;
  localparam int         LIM = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0_req, m1_req, m0_wr, m1_wr, m0_lock, m1_lock;
  logic [2:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_ack, m1_ack, m0_err, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic       s_en, s_wr, s_busy;
  logic [2:0] s_addr;
  logic [7:0] s_wdata, s_rdata;

  typedef struct packed {logic m; logic [7:0] rd; logic err;} ack_t;
  typedef struct packed {logic wr; logic [2:0] a; logic [7:0] wd;} bus_t;

  ack_t       ack_q[$];
  bus_t       bus_q[$];
  logic [7:0] shadow [8];
  logic [7:0] mem [8];
  logic       mem_load = 1'b1;
  logic [7:0] rd_model [2];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         en_cnt = 0;
  int         bus_pushed = 0;

  regbus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_err(m0_err), .m1_err(m1_err),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .s_en(s_en), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_busy(s_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return (i == 3) ? 8'h42 : (8'hA0 | 8'(i));
  endfunction

  // Slave register file
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 8; i++) mem[i] <= init_val(i);
    end else if (s_en && s_wr) begin
      mem[s_addr] <= s_wdata;
    end
  end
  assign s_rdata = mem[s_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic ackof(input logic m);
    return m ? m1_ack : m0_ack;
  endfunction

  task automatic push_exp(input logic m, input logic wr, input logic [2:0] a,
                          input logic [7:0] wd, input bit tmo);
    if (tmo) begin
      ack_q.push_back({m, 8'h00, 1'b1});
    end else begin
      bus_q.push_back({wr, a, wd});
      bus_pushed++;
      if (wr) begin
        ack_q.push_back({m, 8'h00, 1'b0});
        shadow[a] = wd;
      end else begin
        ack_q.push_back({m, shadow[a], 1'b0});
      end
    end
  endtask

  task automatic set_m(input logic m, input logic req, input logic wr,
                       input logic [2:0] a, input logic [7:0] wd, input logic lk);
    if (m) begin
      m1_req = req; m1_wr = wr; m1_addr = a; m1_wdata = wd; m1_lock = lk;
    end else begin
      m0_req = req; m0_wr = wr; m0_addr = a; m0_wdata = wd; m0_lock = lk;
    end
  endtask

  task automatic drop_req(input logic m);
    if (m) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  // Waits for master m's ack; latency is measured in cycles from t0.
  task automatic wait_ack(input logic m, input int t0, input int exp_lat, input string tag);
    bit got;
    got = 0;
    for (int k = 0; k < LIM && !got; k++) begin
      @(negedge clk);
      if (ackof(m)) begin
        got = 1;
        check(tag, 32'(cyc - t0), 32'(exp_lat));
      end
    end
    if (!got) check(tag, 32'hFFFF_FFFF, 32'(exp_lat));
  endtask

  // Single-master transaction; slave is busy for the first `busy` ACCESS-side cycles.
  task automatic txn(input logic m, input logic wr, input logic [2:0] a, input logic [7:0] wd,
                     input int busy, input bit early, input int exp_lat, input string tag);
    int t0;
    bit got;
    got = 0;
    push_exp(m, wr, a, wd, busy > int'(TMO));
    set_m(m, 1'b1, wr, a, wd, 1'b0);
    s_busy = 1'b0;
    t0 = cyc;
    for (int c = 1; c <= LIM && !got; c++) begin
      @(posedge clk); #1;
      s_busy = (c <= busy);
      if (early) drop_req(m);
      @(negedge clk);
      if (ackof(m)) begin
        got = 1;
        check(tag, 32'(cyc - t0), 32'(exp_lat));
      end
    end
    if (!got) check(tag, 32'hFFFF_FFFF, 32'(exp_lat));
    @(posedge clk); #1;
    drop_req(m);
    s_busy = 1'b0;
  endtask

  // Bus and completion monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_model[0] <= 8'h00;
      rd_model[1] <= 8'h00;
    end else begin
      if (s_en) begin
        check("en_while_busy", 32'(s_busy), 32'd0);
        if (bus_q.size() == 0) begin
          check("unexpected_s_en", 32'd1, 32'd0);
        end else begin
          check("bus_cmd", 32'({s_wr, s_addr, s_wdata}), 32'(bus_q[0]));
          void'(bus_q.pop_front());
        end
        en_cnt <= en_cnt + 1;
      end
      if (m0_ack || m1_ack) begin
        if (m0_ack && m1_ack) check("dual_ack", 32'd1, 32'd0);
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          check("ack_owner", 32'(m1_ack), 32'(ack_q[0].m));
          if (!ack_q[0].m) begin
            check("m0_rdata", 32'(m0_rdata), 32'(ack_q[0].rd));
            check("m0_err", 32'(m0_err), 32'(ack_q[0].err));
            check("m1_rdata_hold", 32'(m1_rdata), 32'(rd_model[1]));
            check("m1_err_idle", 32'(m1_err), 32'd0);
            rd_model[0] <= ack_q[0].rd;
          end else begin
            check("m1_rdata", 32'(m1_rdata), 32'(ack_q[0].rd));
            check("m1_err", 32'(m1_err), 32'(ack_q[0].err));
            check("m0_rdata_hold", 32'(m0_rdata), 32'(rd_model[0]));
            check("m0_err_idle", 32'(m0_err), 32'd0);
            rd_model[1] <= ack_q[0].rd;
          end
          void'(ack_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int en0;
    m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0; m0_lock = 0; m1_lock = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; s_busy = 0;
    for (int i = 0; i < 8; i++) shadow[i] = init_val(i);

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({s_en, s_wr, s_addr, s_wdata, m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    mem_load = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous writes after reset: m0 first, then m1
    push_exp(1'b0, 1'b1, 3'd1, 8'h11, 1'b0);
    push_exp(1'b1, 1'b1, 3'd2, 8'h22, 1'b0);
    set_m(1'b0, 1'b1, 1'b1, 3'd1, 8'h11, 1'b0);
    set_m(1'b1, 1'b1, 1'b1, 3'd2, 8'h22, 1'b0);
    t0 = cyc; en0 = en_cnt;
    wait_ack(1'b0, t0, 2, "tie_m0_lat");
    @(posedge clk); #1; drop_req(1'b0);
    wait_ack(1'b1, t0, 5, "tie_m1_lat");
    @(posedge clk); #1; drop_req(1'b1);
    check("tie_en_pulses", 32'(en_cnt - en0), 32'd2);

    txn(1'b0, 1'b0, 3'd3, 8'h00, 0,    1'b0, 2,  "rd_m0_a3_lat");
    txn(1'b1, 1'b0, 3'd2, 8'h00, 0,    1'b1, 2,  "rd_m1_early_drop_lat");
    txn(1'b0, 1'b0, 3'd1, 8'h00, 5,    1'b0, 7,  "rd_busy5_lat");
    txn(1'b1, 1'b1, 3'd4, 8'h44, 10,   1'b0, 12, "wr_busy_at_limit_lat");
    txn(1'b0, 1'b1, 3'd6, 8'h66, 1000, 1'b0, 12, "wr_timeout_lat");
    txn(1'b0, 1'b0, 3'd6, 8'h00, 0,    1'b0, 2,  "rd_after_timeout_lat");

    // m1 lock with both requesting continuously: m1, m1, then m0
    push_exp(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    push_exp(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    push_exp(1'b0, 1'b0, 3'd4, 8'h00, 1'b0);
    set_m(1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1);
    set_m(1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    t0 = cyc;
    wait_ack(1'b1, t0, 2, "lock1_first_lat");
    @(posedge clk); #1; m1_lock = 1'b0;
    wait_ack(1'b1, t0, 5, "lock1_second_lat");
    @(posedge clk); #1;
    @(posedge clk); #1; drop_req(1'b1);
    wait_ack(1'b0, t0, 8, "lock1_release_lat");
    @(posedge clk); #1; drop_req(1'b0);

    txn(1'b0, 1'b0, 3'd3, 8'h00, 0, 1'b0, 2, "rd_before_rst_lat");

    // Reset during a busy ACCESS: transaction abandoned, no ack
    set_m(1'b0, 1'b1, 1'b1, 3'd5, 8'hA5, 1'b0);
    s_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_bus", 32'({s_en, s_wr, s_addr, s_wdata}), 32'({1'b0, 1'b1, 3'd5, 8'hA5}));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({s_en, s_wr, s_addr, s_wdata, m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    check("midrst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    drop_req(1'b0);
    s_busy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie after reset with m0 lock: m0, m0, then m1
    push_exp(1'b0, 1'b0, 3'd4, 8'h00, 1'b0);
    push_exp(1'b0, 1'b0, 3'd4, 8'h00, 1'b0);
    push_exp(1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
    set_m(1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 1'b1);
    set_m(1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
    t0 = cyc;
    wait_ack(1'b0, t0, 2, "lock0_first_lat");
    @(posedge clk); #1; m0_lock = 1'b0;
    wait_ack(1'b0, t0, 5, "lock0_second_lat");
    @(posedge clk); #1;
    @(posedge clk); #1; drop_req(1'b0);
    wait_ack(1'b1, t0, 8, "lock0_release_lat");
    @(posedge clk); #1; drop_req(1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("s_en_total", 32'(en_cnt), 32'(bus_pushed));
    check("scoreboard_left", 32'(ack_q.size() + bus_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regbus_arbiter.md
REGBUS_ARBITER -- requirements
Module: regbus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255: maximum s_busy wait cycles before a transaction aborts.
REQ-002 SHALL have port clk, input, 1: system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_req, m1_req, inputs, 1 each: transaction request from master 0 (SPI bridge) and master 1 (UART command engine).
REQ-005 SHALL have ports m0_wr, m1_wr, inputs, 1 each: 1 = write, 0 = read.
REQ-006 SHALL have ports m0_addr, m1_addr, inputs, 3 each: register address.
REQ-007 SHALL have ports m0_wdata, m1_wdata, inputs, 8 each: write data.
REQ-008 SHALL have ports m0_lock, m1_lock, inputs, 1 each: keep the grant for the next transaction.
REQ-009 SHALL have ports m0_ack, m1_ack, outputs, 1 each: one-cycle completion pulse.
REQ-010 SHALL have ports m0_err, m1_err, outputs, 1 each: timeout flag, valid only with the matching ack.
REQ-011 SHALL have ports m0_rdata, m1_rdata, outputs, 8 each: read data, valid with the matching ack.
REQ-012 SHALL have ports s_en (output, 1), s_wr (output, 1), s_addr (output, 3) and s_wdata (output, 8): slave register bus.
REQ-013 SHALL have ports s_rdata (input, 8) and s_busy (input, 1): slave read data and slave not-ready.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-015 IDLE behaviour SHALL be:
- on any mX_req = 1, latch owner, wr, addr and wdata into bus registers and go to ACCESS;
- otherwise stay in IDLE.
REQ-016 Owner selection SHALL follow these rules, in priority order:
- if lock_valid is set and the locked master requests, that master wins;
- otherwise, with both requesting, the master not granted last wins (round-robin);
- otherwise the single requester wins.
REQ-017 s_wr, s_addr and s_wdata SHALL be driven from the bus registers and stay stable throughout ACCESS.
REQ-018 s_en SHALL equal (state == ACCESS && !s_busy), combinationally; at most one s_en cycle per transaction.
REQ-019 On the edge ending an s_en cycle, the block SHALL capture s_rdata (reads; 8'h00 on writes) into the owner's rdata register and go to DONE.
REQ-020 While in ACCESS with s_busy = 1, an 8-bit wait counter SHALL increment.
REQ-021 When the wait counter reaches TIMEOUT while s_busy = 1, the block SHALL:
- go to DONE with no s_en issued;
- set the owner's rdata to 8'h00 and its err to 1.
REQ-022 In DONE, the owner's ack SHALL be 1 for exactly one cycle with rdata/err valid, then the FSM SHALL return to IDLE.
REQ-023 In DONE, the block SHALL record last_grant = owner and clear the wait counter.
REQ-024 In DONE, the block SHALL set lock_valid = owner's mX_lock.
REQ-025 Minimum latency SHALL be: req sampled at edge 0, s_en in cycle 1, ack in cycle 2; three cycles per transaction.
REQ-026 Masters SHALL drop req at the edge sampling ack; req dropped earlier SHALL NOT cancel a latched transaction, and ack is still issued.
REQ-027 The non-owner's ack and err SHALL stay 0; its rdata SHALL hold its previous value.
REQ-028 Request and lock inputs SHALL be ignored in ACCESS and DONE; the arbiter is not preemptive.
REQ-029 With TIMEOUT = 0, a busy slave SHALL abort on the first s_busy = 1 cycle of ACCESS.

Reset
REQ-030 On rst_n = 0, the block SHALL asynchronously:
- set state = IDLE, s_en = 0, s_wr = 0, s_addr = 0 and s_wdata = 0;
- set all acks = 0, all errs = 0 and both rdata = 8'h00;
- set last_grant = 1 (m0 wins the first tie), lock_valid = 0 and the wait counter = 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no ack issued; the first post-reset arbitration obeys REQ-030.

Verification
REQ-032 m0 read addr 3, s_rdata = 8'h42, s_busy = 0 -> s_en in cycle 1 with s_wr = 0 and s_addr = 3; m0_ack in cycle 2 with m0_rdata = 8'h42 and m0_err = 0.
REQ-033 m0 and m1 request writes in the same cycle after reset -> m0 is served first; then m1 is served with s_wdata = m1_wdata; two s_en pulses total, six cycles.
REQ-034 m0 asserts lock with continuous requests from m0 and m1 -> m0 is granted twice in a row; after lock drops, m1 is granted next.
REQ-035 s_busy = 1 for 5 cycles, TIMEOUT = 255 -> s_en is asserted in the 6th ACCESS cycle; ack follows with err = 0.
REQ-036 s_busy stuck at 1, TIMEOUT = 8'd10 -> no s_en; ack with err = 1 and rdata = 8'h00; the next request is served normally.
REQ-037 rst_n pulsed low during ACCESS -> all outputs return to reset values immediately and no ack is issued; a tie after reset is granted to m0.
